// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared defaults and read-tag type for ram_sp_arb
package ram_arb_pkg;

  localparam int NUM_REQ_DEF = 2;
  localparam int RD_LAT_DEF  = 7;
  localparam int TAG_ID_W    = 8;

  // One entry of the read-return pipeline: which requester owns the data.
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant with a pointer that advances past the winner
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win;

  // Scan from the farthest offset down so the pointer-nearest request wins.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    win   = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        win        = PTR_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
    end
  end

endmodule

// File: rtl/ram_sp_arb.sv
// rtl/ram_sp_arb.sv - round-robin sharing of one fixed-latency single-port RAM
module ram_sp_arb
  import ram_arb_pkg::*;
#(
  parameter int  NUM_REQ    = NUM_REQ_DEF,
  parameter int  MEM_DEPTH  = 64,
  parameter int  BYTE_WIDTH = 8,
  parameter int  BYTE_NUM   = 4,
  parameter int  RD_LAT     = RD_LAT_DEF,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH),
  localparam int MEM_WIDTH  = BYTE_WIDTH * BYTE_NUM
) (
  input  logic                            clk_i,
  input  logic                            arstn_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ*BYTE_NUM-1:0]     req_wr_en_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ*MEM_WIDTH-1:0]    req_data_i,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  output logic [MEM_WIDTH-1:0]            rsp_data_o,
  output logic                            ram_en_o,
  output logic [BYTE_NUM-1:0]             ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0]           ram_addr_o,
  output logic [MEM_WIDTH-1:0]            ram_data_o,
  input  logic [MEM_WIDTH-1:0]            ram_data_i
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    grant;
  logic                  xfer;
  logic [BYTE_NUM-1:0]   sel_wr_en;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [MEM_WIDTH-1:0]  sel_data;
  logic [ID_W-1:0]       sel_id;
  logic [ID_W-1:0]       ram_id;
  rd_tag_t               tag_in;
  rd_tag_t               tag_pipe [RD_LAT];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk     (clk_i),
    .rst_n   (arstn_i),
    .req     (req_valid_i),
    .advance (xfer),
    .grant   (grant)
  );

  // Ready is forced low while reset is held so nothing is accepted then.
  assign req_ready_o = grant & {NUM_REQ{arstn_i}};
  assign xfer        = |req_ready_o;

  always_comb begin
    sel_wr_en = '0;
    sel_addr  = '0;
    sel_data  = '0;
    sel_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_wr_en = req_wr_en_i[i*BYTE_NUM +: BYTE_NUM];
        sel_addr  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data  = req_data_i[i*MEM_WIDTH +: MEM_WIDTH];
        sel_id    = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      ram_en_o    <= 1'b0;
      ram_wr_en_o <= '0;
      ram_addr_o  <= '0;
      ram_data_o  <= '0;
      ram_id      <= '0;
    end else begin
      ram_en_o    <= xfer;
      ram_wr_en_o <= xfer ? sel_wr_en : '0;
      if (xfer) begin
        ram_addr_o <= sel_addr;
        ram_data_o <= sel_data;
        ram_id     <= sel_id;
      end
    end
  end

  always_comb begin
    tag_in.valid = ram_en_o && (ram_wr_en_o == '0);
    tag_in.id    = TAG_ID_W'(ram_id);
  end

  // Tag rides alongside the RAM access; its tail lines up with ram_data_i.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_o[i] = tag_pipe[RD_LAT-1].valid && (tag_pipe[RD_LAT-1].id == TAG_ID_W'(i));
    end
  end

  assign rsp_data_o = ram_data_i;

endmodule
